// File: rtl/mac_pkg.sv
// mac_pkg
// Shared types and constants for the two-requester MAC arbiter.
//   state_t      : arbiter FSM states (IDLE, GRANT0, GRANT1, DRAIN)
//   MODE_0/1     : MAC operating modes carried on reqN_mode / mac_mode
//   *_DEF        : default parameter values used by mac_arbiter
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic MODE_0 = 1'b0;
  localparam logic MODE_1 = 1'b1;

  localparam int DATA_W_DEF    = 16;
  localparam int DRAIN_CYC_DEF = 3;
  localparam int TIMEOUT_DEF   = 64;

endpackage

// File: rtl/mac_arb_rr.sv
// mac_arb_rr
// Two-way round-robin picker. A lone requester always wins; when both
// request, prio selects the winner (0 -> requester 0, 1 -> requester 1).
// Ports:
//   req  in  [1:0]  request vector
//   prio in  1      preferred requester on contention
//   gnt  out [1:0]  one-hot grant (all zero when nobody requests)
module mac_arb_rr
  import mac_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter
// Arbitrates two packet requesters onto a single MAC. A granted requester
// owns the MAC from its first beat until the packet has drained; MAC
// responses are steered back to the owner with zero latency.
//
// Parameters:
//   DATA_W    operand width
//   DRAIN_CYC mode-0 drain length in cycles
//   TIMEOUT   mode-1 mac_done watchdog limit (only with MAC_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   reqN_valid/last/mode/data     requester beats (N = 0, 1)
//   reqN_ready                    beat accepted when valid & ready
//   mac_mode, mac_valid_in,
//   mac_last_in, mac_data         registered beat stream to the MAC
//   mac_valid_out, mac_done       MAC result valid / mode-1 completion
//   rspN_valid, doneN             MAC responses routed to the packet owner
//   timeout_err                   one-cycle watchdog pulse (optional)
//
// Build option:
//   MAC_ARB_TIMEOUT_EN  adds the timeout_err port and a mode-1 watchdog.
//   Without it, mode-1 DRAIN waits for mac_done indefinitely.
module mac_arbiter
  import mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_last,
  input  logic              req1_last,
  input  logic              req0_mode,
  input  logic              req1_mode,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              mac_mode,
  output logic              mac_valid_in,
  output logic              mac_last_in,
  output logic [DATA_W-1:0] mac_data,
  input  logic              mac_valid_out,
  input  logic              mac_done,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic              done0,
  output logic              done1
`ifdef MAC_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  // One DRAIN-cycle counter serves the mode-0 drain length and, when
  // enabled, the mode-1 watchdog; the packet mode never changes inside
  // DRAIN, so the two uses never overlap. It is sized for the larger limit.
  localparam int CNT_LIM = (DRAIN_CYC > TIMEOUT) ? DRAIN_CYC : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_LIM + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prio;
  logic               r_owner;
  logic               r_pkt_mode;
  logic               r_first;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mac_valid_p1;
  logic               r_mac_last_p1;
  logic [DATA_W-1:0]  r_mac_data_p1;

  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_granted;
  logic               w_busy;
  logic               w_beat_valid;
  logic               w_beat_last;
  logic               w_beat_mode;
  logic [DATA_W-1:0]  w_beat_data;
  logic               w_accept;
  logic               w_mode_eff;
  logic               w_cnt_done;
  logic               w_drain_exit;

  assign w_req = {req1_valid, req0_valid};

  mac_arb_rr u_rr (
    .req  (w_req),
    .prio (r_prio),
    .gnt  (w_gnt)
  );

  // Owner's beat, selected once so the accept path is shared.
  assign w_beat_valid = r_owner ? req1_valid : req0_valid;
  assign w_beat_last  = r_owner ? req1_last  : req0_last;
  assign w_beat_mode  = r_owner ? req1_mode  : req0_mode;
  assign w_beat_data  = r_owner ? req1_data  : req0_data;

  assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_busy    = (r_state != IDLE);
  assign w_accept  = w_granted && w_beat_valid;

  // The first accepted beat decides the packet mode; later beats' mode
  // bits are ignored.
  assign w_mode_eff = r_first ? w_beat_mode : r_pkt_mode;

  assign w_cnt_done = (r_cnt == CNT_W'(DRAIN_CYC - 1));

`ifdef MAC_ARB_TIMEOUT_EN
  logic w_wd_expire;
  // mac_done in the expiry cycle wins: it is a normal completion.
  assign w_wd_expire = (r_state == DRAIN) && (r_pkt_mode == MODE_1) &&
                       (r_cnt == CNT_W'(TIMEOUT - 1)) && !mac_done;
  assign timeout_err = w_wd_expire;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_exit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt[0]) begin
          w_state_nxt = GRANT0;
        end else if (w_gnt[1]) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (w_accept && w_beat_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_pkt_mode == MODE_0) begin
          w_drain_exit = w_cnt_done;
        end else begin
          w_drain_exit = mac_done;
`ifdef MAC_ARB_TIMEOUT_EN
          if (w_wd_expire) begin
            w_drain_exit = 1'b1;
          end
`endif
        end
        if (w_drain_exit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_prio         <= 1'b0;
      r_owner        <= 1'b0;
      r_pkt_mode     <= MODE_0;
      r_first        <= 1'b0;
      r_cnt          <= '0;
      r_mac_valid_p1 <= 1'b0;
      r_mac_last_p1  <= 1'b0;
      r_mac_data_p1  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == IDLE) && (|w_gnt)) begin
        r_owner <= w_gnt[1];
        r_first <= 1'b1;
      end

      if (w_accept) begin
        r_pkt_mode <= w_mode_eff;
        r_first    <= 1'b0;
      end

      if (r_state == DRAIN) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      // The requester that did not own the finished packet goes next.
      if (w_drain_exit) begin
        r_prio <= ~r_owner;
      end

      // ---- stage p1: accepted beat to MAC ----
      r_mac_valid_p1 <= w_accept;
      r_mac_last_p1  <= w_accept && w_beat_last && (w_mode_eff == MODE_1);
      if (w_accept) begin
        r_mac_data_p1 <= w_beat_data;
      end
    end
  end

  assign req0_ready   = (r_state == GRANT0);
  assign req1_ready   = (r_state == GRANT1);

  assign mac_mode     = r_pkt_mode;
  assign mac_valid_in = r_mac_valid_p1;
  assign mac_last_in  = r_mac_last_p1;
  assign mac_data     = r_mac_data_p1;

  // Responses go straight to the owner; in IDLE they are dropped.
  assign rsp0_valid = w_busy && !r_owner && mac_valid_out;
  assign rsp1_valid = w_busy &&  r_owner && mac_valid_out;
  assign done0      = w_busy && !r_owner && mac_done;
  assign done1      = w_busy &&  r_owner && mac_done;

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, operand width; DRAIN_CYC, default 3, mode-0 drain cycles; TIMEOUT, default 64, mode-1 done watchdog limit.
REQ-002 Port: clk  in  1  single clock, all logic on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high.
REQ-004 Ports: req0_valid, req1_valid  in  1 each  requester beat valid.
REQ-005 Ports: req0_last, req1_last  in  1 each  final beat of packet.
REQ-006 Ports: req0_mode, req1_mode  in  1 each  MAC mode, 0 or 1.
REQ-007 Ports: req0_data, req1_data  in  DATA_W each  operand.
REQ-008 Ports: req0_ready, req1_ready  out  1 each  beat accepted when valid&ready.
REQ-009 Ports: mac_mode, mac_valid_in, mac_last_in  out  1 each  registered MAC controls.
REQ-010 Port: mac_data  out  DATA_W  registered operand to MAC.
REQ-011 Ports: mac_valid_out, mac_done  in  1 each  MAC result valid and mode-1 done.
REQ-012 Ports: rsp0_valid, rsp1_valid, done0, done1  out  1 each  MAC responses routed to packet owner.
REQ-013 Port: timeout_err  out  1  one-cycle watchdog pulse, present only with MAC_ARB_TIMEOUT_EN.

Function
REQ-014 FSM states SHALL be IDLE, GRANT0, GRANT1, DRAIN.
REQ-015 In IDLE, the requester with valid=1 SHALL be granted. If both are valid, the requester selected by the round-robin pointer `prio` SHALL be granted; `prio` resets to 0.
REQ-016 Transition to GRANTn SHALL occur one cycle after selection. Only the granted reqN_ready SHALL be 1, and only in GRANTn.
REQ-017 Mode SHALL be captured from the first accepted beat into `pkt_mode`. The mode on later beats of the packet SHALL be ignored.
REQ-018 Each accepted beat SHALL appear on mac_valid_in/mac_data exactly 1 cycle later, with mac_mode=pkt_mode. mac_valid_in SHALL be 0 on all cycles without an accepted beat.
REQ-019 The last flag SHALL be forwarded on mac_last_in with the beat only when pkt_mode=1, and forced to 0 when pkt_mode=0.
REQ-020 Accepting a beat with last=1 SHALL move GRANTn to DRAIN. ready SHALL be 0 throughout DRAIN.
REQ-021 DRAIN with pkt_mode=0 SHALL last exactly DRAIN_CYC cycles, then go to IDLE.
REQ-022 DRAIN with pkt_mode=1 SHALL exit to IDLE on the cycle after mac_done=1.
REQ-023 On every DRAIN exit, `prio` SHALL point to the requester that did not own the finished packet.
REQ-024 During GRANTn and DRAIN, mac_valid_out SHALL be routed to rspN_valid and mac_done to doneN of the owner, combinationally and with zero latency. The non-owner outputs SHALL be 0.
REQ-025 In IDLE, mac_valid_out and mac_done SHALL be discarded.
REQ-026 A granted requester holding valid=0 mid-packet SHALL keep the grant indefinitely; there is no preemption.
REQ-027 mac_done arriving in the same DRAIN cycle as a counter or timeout expiry SHALL be treated as a normal completion, with no error.

Reset
REQ-028 reset SHALL force: state=IDLE, prio=0, pkt_mode=0, owner=0, counters=0, all outputs 0.
REQ-029 reset mid-packet SHALL abandon the packet. The first post-reset grant SHALL follow REQ-015.

Configuration
REQ-030 With MAC_ARB_TIMEOUT_EN defined: if mac_done is not seen within TIMEOUT DRAIN cycles in mode 1, the block SHALL go to IDLE, pulse timeout_err for 1 cycle, and advance prio.
REQ-031 Without MAC_ARB_TIMEOUT_EN, the timeout_err port and the watchdog counter SHALL be absent, and mode-1 DRAIN SHALL wait unbounded for mac_done.

Structure
REQ-032 Package mac_pkg SHALL hold the state enum type, the MODE_0/MODE_1 constants and the default widths.
REQ-033 The sole sub-module SHALL be mac_arb_rr, a 2-way round-robin picker with inputs req[1:0] and prio, and output gnt[1:0].

Verification
REQ-034 Release reset; req0 sends 3 beats, mode 0, data 1,2,3 → mac_valid_in high 3 cycles carrying 1,2,3; mac_last_in=0; DRAIN lasts 3 cycles; prio=1.
REQ-035 req0 and req1 valid together from IDLE with prio=0 → req0 granted first; req1 granted immediately after req0's DRAIN completes.
REQ-036 req1 sends a mode-1 packet of 2 beats; mac_done is pulsed 5 cycles after the last beat → done1=1 for that cycle, done0=0, then the block returns to IDLE.
REQ-037 reset asserted on the second beat of a 4-beat packet → next cycle all outputs are 0 and state=IDLE; a new req1 request is granted.
REQ-038 With MAC_ARB_TIMEOUT_EN and TIMEOUT=8, mode-1 packet with mac_done withheld → timeout_err pulses on the 8th DRAIN cycle, then the block returns to IDLE.
REQ-039 Mode toggled on beat 2 of a mode-1 packet → mac_mode stays 1 for all beats.
